// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control sequencer: opcodes, states,
// ALU/write-back selects, branch conditions and the registered strobe bundle.
package ctrl_pkg;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_LD   = 5'b00011;
    localparam logic [4:0] OP_ST   = 5'b00101;
    localparam logic [4:0] OP_BR   = 5'b11001;
    localparam logic [4:0] OP_JAL  = 5'b10010;
    localparam logic [4:0] OP_HLT  = 5'b11100;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_OR = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC = 2'b10
    } wb_sel_t;

    typedef enum logic [1:0] {
        COND_Z = 2'b00, COND_NZ = 2'b01, COND_C = 2'b10, COND_AL = 2'b11
    } cond_t;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_ADDI, CLS_LD, CLS_ST, CLS_BR, CLS_JAL, CLS_HLT, CLS_ILL
    } op_class_t;

    typedef struct packed {
        logic    mem_req;
        logic    mem_we;
        logic    pc_inc;
        logic    pc_load;
        logic    psw_load;
        logic    rf_we;
        logic    alu_src_b;
        logic    done;
        logic    fault;
        alu_op_t alu_op;
        wb_sel_t wb_sel;
    } strobe_t;

    function automatic logic br_taken(cond_t cond, logic z, logic c);
        logic taken;
        case (cond)
            COND_Z:  taken = z;
            COND_NZ: taken = ~z;
            COND_C:  taken = c;
            default: taken = 1'b1;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Memory handshake and datapath strobe bundle between the sequencer (master)
// and the datapath/memory side (slave).
interface ctrl_sequencer_if #(parameter int IW = 16);

    logic [IW-1:0] Ins;
    logic          MemRdy;
    logic [2:0]    PSW_NZC;
    logic          MemReq;
    logic          MemWe;
    logic          IrLoad;
    logic          PcInc;
    logic          PcLoad;
    logic [1:0]    AluOp;
    logic          AluSrcB;
    logic          PswLoad;
    logic          RfWe;
    logic [1:0]    WbSel;
    logic          Illegal;
    logic          Fault;
    logic          Done;

    modport master (
        input  Ins, MemRdy, PSW_NZC,
        output MemReq, MemWe, IrLoad, PcInc, PcLoad, AluOp, AluSrcB,
               PswLoad, RfWe, WbSel, Illegal, Fault, Done
    );

    modport slave (
        output Ins, MemRdy, PSW_NZC,
        input  MemReq, MemWe, IrLoad, PcInc, PcLoad, AluOp, AluSrcB,
               PswLoad, RfWe, WbSel, Illegal, Fault, Done
    );

endinterface

// File: rtl/ctrl_opdecode.sv
// Combinational instruction-register decode: opcode class, ALU controls,
// branch condition field and opcode legality.
module ctrl_opdecode
    import ctrl_pkg::*;
#(
    parameter int IW = 16
) (
    input  logic [IW-1:0] ir,
    output op_class_t     cls,
    output alu_op_t       alu_op,
    output logic          alu_src_b,
    output cond_t         cond,
    output logic          legal
);

    logic [4:0] opcode;
    logic       unused_bits;

    assign opcode      = ir[IW-1 -: 5];
    assign cond        = cond_t'(ir[9:8]);
    assign unused_bits = ^{ir[IW-6:10], ir[7:2]};

    always_comb begin
        cls       = CLS_ILL;
        alu_op    = ALU_ADD;
        alu_src_b = 1'b0;
        case (opcode)
            OP_ALU: begin
                cls    = CLS_ALU;
                alu_op = alu_op_t'(ir[1:0]);
            end
            OP_ADDI: begin
                cls       = CLS_ADDI;
                alu_src_b = 1'b1;
            end
            OP_LD: begin
                cls       = CLS_LD;
                alu_src_b = 1'b1;
            end
            // Stores compute their address the same way loads do.
            OP_ST: begin
                cls       = CLS_ST;
                alu_src_b = 1'b1;
            end
            OP_BR:   cls = CLS_BR;
            OP_JAL:  cls = CLS_JAL;
            OP_HLT:  cls = CLS_HLT;
            default: cls = CLS_ILL;
        endcase
    end

    assign legal = (cls != CLS_ILL);

endmodule

// File: rtl/ctrl_sequencer.sv
// Multicycle step sequencer: owns state, IR and the memory wait counter, and
// drives registered control strobes that Rst forces low in the same cycle.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int IW       = 16,
    parameter int WAIT_MAX = 15
) (
    input logic            Clk,
    input logic            Rst,
    ctrl_sequencer_if.master bus
);

    localparam int WCW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WCW-1:0] WAIT_LIM = WCW'(WAIT_MAX);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ir;
    logic [WCW-1:0] wcnt;
    strobe_t       strb;

    op_class_t cls;
    alu_op_t   dec_alu;
    logic      dec_srcb;
    cond_t     dec_cond;
    logic      dec_legal;
    logic      mem_phase;
    logic      timeout;
    logic      br_take;
    logic      unused_n;

    ctrl_opdecode #(.IW(IW)) u_dec (
        .ir        (ir),
        .cls       (cls),
        .alu_op    (dec_alu),
        .alu_src_b (dec_srcb),
        .cond      (dec_cond),
        .legal     (dec_legal)
    );

    assign mem_phase = (state == S_FETCH) || (state == S_MEM);
    // MemRdy in the limit cycle still completes the access.
    assign timeout   = (WAIT_MAX != 0) && mem_phase && !bus.MemRdy && (wcnt == WAIT_LIM);

    function automatic strobe_t entry_strobes(state_t s, op_class_t c, alu_op_t a, logic srcb);
        strobe_t st;
        st = '0;
        case (s)
            S_FETCH:  st.mem_req = 1'b1;
            S_DECODE: st.pc_inc  = 1'b1;
            S_EXEC: begin
                st.alu_op    = a;
                st.alu_src_b = srcb;
                st.psw_load  = (c == CLS_ALU) || (c == CLS_ADDI);
                st.pc_load   = (c == CLS_JAL);
            end
            S_MEM: begin
                st.mem_req = 1'b1;
                st.mem_we  = (c == CLS_ST);
            end
            S_WB: begin
                st.rf_we  = 1'b1;
                st.wb_sel = (c == CLS_LD) ? WB_MEM : (c == CLS_JAL) ? WB_PC : WB_ALU;
            end
            S_HALT:  st.done  = 1'b1;
            S_FAULT: st.fault = 1'b1;
            default: st = '0;
        endcase
        return st;
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (bus.MemRdy)   state_nxt = S_DECODE;
                else if (timeout) state_nxt = S_FAULT;
            end
            S_DECODE: begin
                if (!dec_legal)          state_nxt = S_FETCH;
                else if (cls == CLS_HLT) state_nxt = S_HALT;
                else                     state_nxt = S_EXEC;
            end
            S_EXEC: begin
                case (cls)
                    CLS_ALU, CLS_ADDI, CLS_JAL: state_nxt = S_WB;
                    CLS_LD, CLS_ST:             state_nxt = S_MEM;
                    default:                    state_nxt = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (bus.MemRdy)   state_nxt = (cls == CLS_LD) ? S_WB : S_FETCH;
                else if (timeout) state_nxt = S_FAULT;
            end
            S_WB:    state_nxt = S_FETCH;
            default: state_nxt = state;
        endcase
    end

    // Strobes are registered for the state being entered; the decode of IR is
    // already valid whenever an IR-dependent state is entered.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_FETCH;
            ir    <= '0;
            wcnt  <= '0;
            strb  <= entry_strobes(S_FETCH, CLS_ILL, ALU_ADD, 1'b0);
        end else begin
            state <= state_nxt;
            strb  <= entry_strobes(state_nxt, cls, dec_alu, dec_srcb);
            if (state == S_FETCH && bus.MemRdy)
                ir <= bus.Ins;
            if ((WAIT_MAX != 0) && mem_phase && !bus.MemRdy && (state_nxt == state))
                wcnt <= wcnt + 1'b1;
            else
                wcnt <= '0;
        end
    end

    assign br_take  = (state == S_EXEC) && (cls == CLS_BR) &&
                      br_taken(dec_cond, bus.PSW_NZC[1], bus.PSW_NZC[0]);
    assign unused_n = bus.PSW_NZC[2];

    assign bus.MemReq  = ~Rst & strb.mem_req;
    assign bus.MemWe   = ~Rst & strb.mem_we;
    assign bus.IrLoad  = ~Rst & (state == S_FETCH) & bus.MemRdy;
    assign bus.PcInc   = ~Rst & strb.pc_inc;
    assign bus.PcLoad  = ~Rst & (strb.pc_load | br_take);
    assign bus.AluOp   = Rst ? 2'b00 : strb.alu_op;
    assign bus.AluSrcB = ~Rst & strb.alu_src_b;
    assign bus.PswLoad = ~Rst & strb.psw_load;
    assign bus.RfWe    = ~Rst & strb.rf_we;
    assign bus.WbSel   = Rst ? 2'b00 : strb.wb_sel;
    assign bus.Illegal = ~Rst & (state == S_DECODE) & ~dec_legal;
    assign bus.Fault   = ~Rst & strb.fault;
    assign bus.Done    = ~Rst & strb.done;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Cycle-by-cycle bench for ctrl_sequencer: a vector table plus hand-written
// wait/timeout/reset sequences, compared through an expectation queue.
module tb_ctrl_sequencer;

    typedef logic [14:0] obs_t;

    typedef struct {
        string       name;
        logic        r;
        logic [15:0] ins;
        logic        rdy;
        logic [2:0]  nzc;
        obs_t        exp;
    } vec_t;

    typedef struct {
        string name;
        obs_t  exp;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    vec_t tbl[$];
    sb_t  sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    ctrl_sequencer_if #(.IW(16)) bus ();

    ctrl_sequencer #(.IW(16), .WAIT_MAX(15)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Bit order: MemReq MemWe IrLoad PcInc PcLoad AluOp AluSrcB PswLoad RfWe WbSel Illegal Fault Done
    function automatic obs_t o(logic req, logic we, logic irl, logic inc, logic pcl,
                               logic [1:0] aop, logic srcb, logic psw, logic rfwe,
                               logic [1:0] wbs, logic ill, logic flt, logic dn);
        return {req, we, irl, inc, pcl, aop, srcb, psw, rfwe, wbs, ill, flt, dn};
    endfunction

    function automatic logic [15:0] iw(logic [4:0] op, logic [1:0] cond, logic [1:0] func);
        return {op, 1'b0, cond, 6'b000000, func};
    endfunction

    function automatic obs_t exX(logic [1:0] aop, logic srcb, logic psw, logic pcl);
        return o(0, 0, 0, 0, pcl, aop, srcb, psw, 0, 2'b00, 0, 0, 0);
    endfunction

    function automatic obs_t memX(logic we);
        return o(1, we, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0);
    endfunction

    function automatic obs_t wbX(logic [1:0] wbs);
        return o(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, wbs, 0, 0, 0);
    endfunction

    obs_t Z0, FRDY, FWAIT, DEC, DECILL, HALTO, FAULTO;
    logic [15:0] ADD, ORR, ADDI, LD, ST, JAL, BRZ, BRNZ, BRC, BRAL, ILL1, ILL2, HLT;

    task automatic addv(string name, logic r, logic [15:0] ins, logic rdy, logic [2:0] nzc, obs_t exp);
        vec_t v;
        v.name = name; v.r = r; v.ins = ins; v.rdy = rdy; v.nzc = nzc; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic checkOutput();
        sb_t  e;
        obs_t got;
        if (sbq.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty cycle %0d", cyc);
            return;
        end
        e   = sbq.pop_front();
        got = {bus.MemReq, bus.MemWe, bus.IrLoad, bus.PcInc, bus.PcLoad, bus.AluOp,
               bus.AluSrcB, bus.PswLoad, bus.RfWe, bus.WbSel, bus.Illegal, bus.Fault, bus.Done};
        checks++;
        if (got !== e.exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d got=%b want=%b", e.name, cyc, got, e.exp);
        end
    endtask

    task automatic applyStimulus(string name, logic r, logic [15:0] ins, logic rdy,
                                 logic [2:0] nzc, obs_t exp);
        sb_t e;
        @(negedge clk);
        rst         = r;
        bus.Ins     = ins;
        bus.MemRdy  = rdy;
        bus.PSW_NZC = nzc;
        e.name = name;
        e.exp  = exp;
        sbq.push_back(e);
        #1;
        checkOutput();
        cyc++;
    endtask

    initial begin
        bus.Ins     = '0;
        bus.MemRdy  = 1'b0;
        bus.PSW_NZC = 3'b000;

        Z0     = '0;
        FRDY   = o(1, 0, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0);
        FWAIT  = o(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0);
        DEC    = o(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0);
        DECILL = o(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0);
        HALTO  = o(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1);
        FAULTO = o(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 1, 0);

        ADD  = iw(5'b00000, 2'b00, 2'b00);
        ORR  = iw(5'b00000, 2'b00, 2'b11);
        ADDI = iw(5'b01000, 2'b00, 2'b00);
        LD   = iw(5'b00011, 2'b00, 2'b00);
        ST   = iw(5'b00101, 2'b00, 2'b00);
        JAL  = iw(5'b10010, 2'b00, 2'b00);
        BRZ  = iw(5'b11001, 2'b00, 2'b00);
        BRNZ = iw(5'b11001, 2'b01, 2'b00);
        BRC  = iw(5'b11001, 2'b10, 2'b00);
        BRAL = iw(5'b11001, 2'b11, 2'b00);
        ILL1 = iw(5'b11111, 2'b00, 2'b00);
        ILL2 = iw(5'b00001, 2'b00, 2'b00);
        HLT  = iw(5'b11100, 2'b00, 2'b00);

        addv("reset0", 1, ADD, 1, 3'b111, Z0);
        addv("reset1", 1, ADD, 1, 3'b111, Z0);
        addv("add_f", 0, ADD, 1, 0, FRDY);
        addv("add_d", 0, ADD, 1, 0, DEC);
        addv("add_e", 0, ADD, 1, 0, exX(2'b00, 0, 1, 0));
        addv("add_w", 0, ADD, 1, 0, wbX(2'b00));
        addv("or_f", 0, ORR, 1, 0, FRDY);
        addv("or_d", 0, ORR, 1, 0, DEC);
        addv("or_e", 0, ORR, 1, 0, exX(2'b11, 0, 1, 0));
        addv("or_w", 0, ORR, 1, 0, wbX(2'b00));
        addv("addi_f", 0, ADDI, 1, 0, FRDY);
        addv("addi_d", 0, ADDI, 1, 0, DEC);
        addv("addi_e", 0, ADDI, 1, 0, exX(2'b00, 1, 1, 0));
        addv("addi_w", 0, ADDI, 1, 0, wbX(2'b00));
        addv("ld_f", 0, LD, 1, 0, FRDY);
        addv("ld_d", 0, LD, 1, 0, DEC);
        addv("ld_e", 0, LD, 1, 0, exX(2'b00, 1, 0, 0));
        addv("ld_m", 0, LD, 1, 0, memX(0));
        addv("ld_w", 0, LD, 1, 0, wbX(2'b01));
        addv("st_f", 0, ST, 1, 0, FRDY);
        addv("st_d", 0, ST, 1, 0, DEC);
        addv("st_e", 0, ST, 1, 0, exX(2'b00, 1, 0, 0));
        addv("st_m", 0, ST, 1, 0, memX(1));
        addv("jal_f", 0, JAL, 1, 0, FRDY);
        addv("jal_d", 0, JAL, 1, 0, DEC);
        addv("jal_e", 0, JAL, 1, 0, exX(2'b00, 0, 0, 1));
        addv("jal_w", 0, JAL, 1, 0, wbX(2'b10));
        addv("brnz_z1_f", 0, BRNZ, 1, 3'b000, FRDY);
        addv("brnz_z1_d", 0, BRNZ, 1, 3'b000, DEC);
        addv("brnz_z1_e", 0, BRNZ, 1, 3'b010, exX(2'b00, 0, 0, 0));
        addv("brnz_z0_f", 0, BRNZ, 1, 3'b010, FRDY);
        addv("brnz_z0_d", 0, BRNZ, 1, 3'b010, DEC);
        addv("brnz_z0_e", 0, BRNZ, 1, 3'b000, exX(2'b00, 0, 0, 1));
        addv("brz_f", 0, BRZ, 1, 0, FRDY);
        addv("brz_d", 0, BRZ, 1, 0, DEC);
        addv("brz_e", 0, BRZ, 1, 3'b010, exX(2'b00, 0, 0, 1));
        addv("brc_c0_f", 0, BRC, 1, 0, FRDY);
        addv("brc_c0_d", 0, BRC, 1, 3'b001, DEC);
        addv("brc_c0_e", 0, BRC, 1, 3'b110, exX(2'b00, 0, 0, 0));
        addv("brc_c1_f", 0, BRC, 1, 0, FRDY);
        addv("brc_c1_d", 0, BRC, 1, 0, DEC);
        addv("brc_c1_e", 0, BRC, 1, 3'b001, exX(2'b00, 0, 0, 1));
        addv("bral_f", 0, BRAL, 1, 0, FRDY);
        addv("bral_d", 0, BRAL, 1, 0, DEC);
        addv("bral_e", 0, BRAL, 1, 3'b000, exX(2'b00, 0, 0, 1));
        addv("ill1_f", 0, ILL1, 1, 0, FRDY);
        addv("ill1_d", 0, ILL1, 1, 0, DECILL);
        addv("ill2_f", 0, ILL2, 1, 0, FRDY);
        addv("ill2_d", 0, ILL2, 1, 0, DECILL);
        addv("fwait_f0", 0, ADD, 0, 0, FWAIT);
        addv("fwait_f1", 0, ADD, 1, 0, FRDY);
        addv("fwait_d", 0, ADD, 1, 0, DEC);
        addv("fwait_e", 0, ADD, 1, 0, exX(2'b00, 0, 1, 0));
        addv("fwait_w", 0, ADD, 1, 0, wbX(2'b00));
        addv("hlt_f", 0, HLT, 1, 0, FRDY);
        addv("hlt_d", 0, HLT, 1, 0, DEC);
        addv("halt0", 0, ADD, 1, 0, HALTO);
        addv("halt1", 0, ADD, 1, 3'b111, HALTO);
        addv("halt2", 0, ADD, 0, 0, HALTO);

        foreach (tbl[i])
            applyStimulus(tbl[i].name, tbl[i].r, tbl[i].ins, tbl[i].rdy, tbl[i].nzc, tbl[i].exp);

        // Load with three wait cycles in MEM: write-back lands in cycle 8.
        applyStimulus("ldw_rst", 1, LD, 1, 0, Z0);
        applyStimulus("ldw_f", 0, LD, 1, 0, FRDY);
        applyStimulus("ldw_d", 0, LD, 1, 0, DEC);
        applyStimulus("ldw_e", 0, LD, 0, 0, exX(2'b00, 1, 0, 0));
        for (int k = 0; k < 3; k++)
            applyStimulus("ldw_mwait", 0, LD, 0, 0, memX(0));
        applyStimulus("ldw_mrdy", 0, LD, 1, 0, memX(0));
        applyStimulus("ldw_w", 0, LD, 1, 0, wbX(2'b01));

        // Fifteen wait cycles are tolerated; ready in the limit cycle wins.
        for (int k = 0; k < 15; k++)
            applyStimulus("to_wait15", 0, ADD, 0, 0, FWAIT);
        applyStimulus("to_rdy_at_limit", 0, ADD, 1, 0, FRDY);
        applyStimulus("to_nofault_d", 0, ADD, 1, 0, DEC);
        applyStimulus("to_nofault_e", 0, ADD, 1, 0, exX(2'b00, 0, 1, 0));
        applyStimulus("to_nofault_w", 0, ADD, 1, 0, wbX(2'b00));
        for (int k = 0; k < 16; k++)
            applyStimulus("to_wait16", 0, ADD, 0, 0, FWAIT);
        for (int k = 0; k < 3; k++)
            applyStimulus("to_fault_sticky", 0, ADD, 1, 0, FAULTO);
        applyStimulus("to_rst", 1, ADD, 1, 0, Z0);
        applyStimulus("to_after_rst_f", 0, ST, 1, 0, FRDY);

        // Store abandoned by reset while waiting in MEM.
        applyStimulus("strst_d", 0, ST, 1, 0, DEC);
        applyStimulus("strst_e", 0, ST, 0, 0, exX(2'b00, 1, 0, 0));
        applyStimulus("strst_m", 0, ST, 0, 0, memX(1));
        applyStimulus("strst_rst", 1, ST, 0, 0, Z0);
        applyStimulus("strst_f", 0, LD, 0, 0, FWAIT);

        // Timeout while a load waits in MEM.
        applyStimulus("memto_f", 0, LD, 1, 0, FRDY);
        applyStimulus("memto_d", 0, LD, 1, 0, DEC);
        applyStimulus("memto_e", 0, LD, 0, 0, exX(2'b00, 1, 0, 0));
        for (int k = 0; k < 16; k++)
            applyStimulus("memto_wait", 0, LD, 0, 0, memX(0));
        applyStimulus("memto_fault", 0, LD, 1, 0, FAULTO);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Parametrised multicycle control unit for the 16-bit RISC core: owns the step state machine, the instruction register and the memory handshake, and drives every datapath control strobe. It replaces the combinational decoder plus external step counter. Added behaviour: variable memory latency via a ready handshake, a bus-timeout fault, and illegal-opcode flagging.

## Interface
- IW, 16: instruction width (≥16); opcode = Ins[IW-1:IW-5], func = Ins[1:0], cond = Ins[9:8].
- WAIT_MAX, 15: max wait cycles per memory access before fault; 0 disables timeout.
- Clk  in  1  rising-edge clock.
- Rst  in  1  reset, synchronous, active-high.
- Ins  in  IW  memory read data, latched into IR when a fetch completes.
- MemRdy  in  1  memory completes current access this cycle.
- PSW_NZC  in  3  flags {N,Z,C}, sampled in EXEC.
- MemReq  out  1  memory access request (FETCH, MEM).
- MemWe  out  1  write qualifier (MEM of ST).
- IrLoad  out  1  IR capture strobe (FETCH && MemRdy).
- PcInc  out  1  PC+1 (DECODE).
- PcLoad  out  1  PC ← target (EXEC of taken BR, JAL).
- AluOp  out  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- AluSrcB  out  1  1 = immediate.
- PswLoad  out  1  flag register update.
- RfWe  out  1  register-file write (WB).
- WbSel  out  2  00 ALU, 01 MEM, 10 PC (link).
- Illegal  out  1  one-cycle pulse on undefined opcode.
- Fault  out  1  sticky bus-timeout flag.
- Done  out  1  high while halted.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT. Reset → FETCH, IR = 0, wait counter = 0.
- FETCH: MemReq=1; hold until MemRdy; then IrLoad=1 → DECODE.
- DECODE: PcInc=1; undefined opcode → Illegal=1, → FETCH (NOP); HLT → HALT; else → EXEC.
- Opcode classes and paths:
  - 00000 ALU-R, AluOp=func, AluSrcB=0: EXEC(PswLoad) → WB(WbSel=00).
  - 01000 ADDI, AluOp=00, AluSrcB=1: EXEC(PswLoad) → WB.
  - 00011 LD: EXEC(addr, AluSrcB=1) → MEM → WB(WbSel=01).
  - 00101 ST: EXEC → MEM(MemWe=1) → FETCH.
  - 11001 BR: cond 00 Z, 01 !Z, 10 C, 11 always; EXEC: PcLoad = condition → FETCH.
  - 10010 JAL: EXEC(PcLoad=1) → WB(WbSel=10).
  - 11100 HLT: HALT, Done=1, held until Rst.
- MEM: MemReq=1 held until MemRdy, then → WB or FETCH.
- Wait counter counts cycles in FETCH/MEM with MemRdy=0; cleared on MemRdy or state exit. Count == WAIT_MAX with MemRdy=0 → FAULT: Fault=1, all strobes 0, held until Rst.
- Outputs Moore-decoded from state and IR; no Ins→output combinational path except IrLoad/MemReq dependence on MemRdy for IrLoad only.

## Timing
- While Rst=1 all outputs forced 0 combinationally the same cycle; first FETCH request in cycle after Rst falls.
- Zero-wait latency: ALU-R/ADDI/JAL 4 cycles, LD 5, ST 4, BR 3, undefined 2.
- Each memory wait cycle adds exactly one cycle.
- MemRdy in the same cycle the counter hits WAIT_MAX: MemRdy wins, no fault.
- Rst during MEM of ST: MemWe drops that cycle; access abandoned.
- PSW_NZC sampled only in EXEC; changes elsewhere ignored.
- MemRdy outside FETCH/MEM ignored.

## Structure
- Package ctrl_pkg: opcode constants, state enum, AluOp and WbSel encodings, cond encodings.
- Sub-module ctrl_opdecode: combinational IR → class, AluOp, AluSrcB, legality; sequencer holds state, IR, wait counter.

## Test plan
- ADD (opcode 00000, func 00), MemRdy tied 1 → states F,D,E,W; RfWe=1, WbSel=00 in cycle 4; PswLoad in cycle 3.
- LD with MemRdy low 3 cycles in MEM → MemReq high 4 cycles, RfWe with WbSel=01 in cycle 8.
- BR cond 01 with Z=1 → PcLoad=0; Z=0 → PcLoad=1; both return to FETCH after 3 cycles.
- WAIT_MAX=15, MemRdy held 0 in FETCH → Fault=1 after 15 wait cycles, sticky; Rst clears; MemRdy on cycle 15 → no fault.
- Opcode 11111 → Illegal one-cycle pulse in DECODE, next cycle FETCH; HLT → Done=1 held, MemReq=0.
- Rst asserted mid-ST MEM → MemWe=0 same cycle, FETCH one cycle after Rst release.
